renkon_output_gather: RTL



---
 rtl/renkon_output_gather.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/renkon_output_gather.sv
// Gathers results from CORE parallel cores onto one output register: manual index select or an
// auto-drain FSM streaming every core buffer out under valid/ready. RENKON_OUT_RELU_EN adds ReLU.
module renkon_output_gather #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned CORE    = 8,
    parameter int unsigned CORELOG = 3,
    parameter int unsigned WORDLOG = 10
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     mode,
    input  logic [CORELOG:0]         output_re,
    input  logic [CORE*DWIDTH-1:0]   read_output_all,
    input  logic                     start,
    input  logic [CORELOG:0]         n_core,
    input  logic [WORDLOG:0]         n_word,
    output logic                     rd_en,
    output logic [WORDLOG-1:0]       rd_addr,
    output logic signed [DWIDTH-1:0] read_output,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned NSEL = 2 ** (CORELOG + 1);
    localparam logic [CORELOG:0] CORE_W   = (CORELOG + 1)'(CORE);
    localparam logic [CORELOG:0] CORE_ONE = {{CORELOG{1'b0}}, 1'b1};
    localparam logic [WORDLOG:0] WORD_ONE = {{WORDLOG{1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StHold, StDone} state_e;

    state_e             state_q, state_d;
    logic [CORELOG:0]   core_idx_q, core_idx_d, n_core_q, n_core_d;
    logic [WORDLOG:0]   word_idx_q, word_idx_d, n_word_q, n_word_d;
    logic [DWIDTH-1:0]  read_output_q, read_output_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    logic [WORDLOG-1:0] rd_addr_q, rd_addr_d;
    logic [CORELOG:0]   sel;

    // Select table padded to the full select range so out-of-range indices read as zero.
    logic [DWIDTH-1:0] core_word [NSEL];
    for (genvar i = 0; i < NSEL; i++) begin : g_sel
        if (i < CORE) begin : g_core
            assign core_word[i] = read_output_all[i*DWIDTH +: DWIDTH];
        end else begin : g_pad
            assign core_word[i] = '0;
        end
    end

    function automatic logic [DWIDTH-1:0] relu(input logic [DWIDTH-1:0] x);
`ifdef RENKON_OUT_RELU_EN
        return x[DWIDTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign sel = output_re - CORE_ONE;

    always_comb begin
        state_d       = state_q;
        core_idx_d    = core_idx_q;
        word_idx_d    = word_idx_q;
        n_core_d      = n_core_q;
        n_word_d      = n_word_q;
        read_output_d = read_output_q;
        out_valid_d   = out_valid_q;
        busy_d        = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start && mode) begin
                    n_core_d    = (n_core > CORE_W) ? CORE_W : n_core;
                    n_word_d    = n_word;
                    core_idx_d  = '0;
                    word_idx_d  = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = (n_core == '0 || n_word == '0) ? StDone : StFetch;
                end else begin
                    read_output_d = relu(core_word[sel]);
                    out_valid_d   = (output_re != '0) && (output_re <= CORE_W);
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                read_output_d = relu(core_word[core_idx_q]);
                out_valid_d   = 1'b1;
                state_d       = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (word_idx_q < n_word_q - WORD_ONE) begin
                        word_idx_d = word_idx_q + WORD_ONE;
                        state_d    = StFetch;
                    end else if (core_idx_q < n_core_q - CORE_ONE) begin
                        word_idx_d = '0;
                        core_idx_d = core_idx_q + CORE_ONE;
                        state_d    = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Strobes are registered from the next state so they line up with it exactly.
        rd_en_d   = (state_d == StFetch);
        rd_addr_d = rd_en_d ? word_idx_d[WORDLOG-1:0] : '0;
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q       <= StIdle;
            core_idx_q    <= '0;
            word_idx_q    <= '0;
            n_core_q      <= '0;
            n_word_q      <= '0;
            read_output_q <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            core_idx_q    <= core_idx_d;
            word_idx_q    <= word_idx_d;
            n_core_q      <= n_core_d;
            n_word_q      <= n_word_d;
            read_output_q <= read_output_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign read_output = read_output_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;

endmodule
